// File: rtl/squash_io_pkg.sv
// Shared definitions for the squash game I/O path: button channel indices,
// debouncer defaults and the strobe classification used by each channel.
package squash_io_pkg;

  localparam int BTN_PAUSE    = 0;
  localparam int BTN_NEW_GAME = 1;
  localparam int BTN_DOWN     = 2;
  localparam int BTN_UP       = 3;

  localparam int DEB_PRESCALE = 250000;
  localparam int DEB_STABLE   = 4;

  typedef enum logic [1:0] {
    STROBE_NONE    = 2'd0,
    STROBE_PRESS   = 2'd1,
    STROBE_RELEASE = 2'd2
  } strobe_e;

endpackage : squash_io_pkg

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser followed by a sampled stability
// filter that accepts a new level after STABLE consecutive differing samples.
module debounce_channel
  import squash_io_pkg::*;
#(
  parameter int STABLE = DEB_STABLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level_n,
  output logic press,
  output logic rel      // release strobe; "release" is a reserved word
);

  localparam int MCW = $clog2(STABLE + 1);
  localparam logic [MCW-1:0] MC_LAST = MCW'(STABLE - 1);

  logic           sync1_r;
  logic           sync2_r;
  logic           state_r;
  logic [MCW-1:0] mc_r;
  logic           press_r;
  logic           release_r;

  logic           state_next_s;
  logic [MCW-1:0] mc_next_s;
  strobe_e        strobe_s;
  logic           press_next_s;
  logic           release_next_s;

  // Qualification: a sample matching the current state clears the count.
  always_comb begin
    state_next_s = state_r;
    mc_next_s    = mc_r;
    strobe_s     = STROBE_NONE;
    if (tick) begin
      if (sync2_r == state_r) begin
        mc_next_s = '0;
      end else if (mc_r == MC_LAST) begin
        state_next_s = sync2_r;
        mc_next_s    = '0;
        strobe_s     = sync2_r ? STROBE_PRESS : STROBE_RELEASE;
      end else begin
        mc_next_s = mc_r + MCW'(1'b1);
      end
    end else begin
      mc_next_s = mc_r;
    end
  end

  // Strobe decode.
  always_comb begin
    press_next_s   = 1'b0;
    release_next_s = 1'b0;
    case (strobe_s)
      STROBE_PRESS:   press_next_s   = 1'b1;
      STROBE_RELEASE: release_next_s = 1'b1;
      default: begin
        press_next_s   = 1'b0;
        release_next_s = 1'b0;
      end
    endcase
  end

  // Synchroniser, filter state and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      state_r   <= 1'b0;
      mc_r      <= '0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      sync1_r   <= raw;
      sync2_r   <= sync1_r;
      state_r   <= state_next_s;
      mc_r      <= mc_next_s;
      press_r   <= press_next_s;
      release_r <= release_next_s;
    end
  end

  assign level_n = ~state_r;
  assign press   = press_r;
  assign rel     = release_r;

endmodule : debounce_channel

// File: rtl/input_debouncer.sv
// Multi-channel push-button conditioner: a shared sample prescaler drives N
// independent debounce channels producing active-low levels and strobes.
module input_debouncer
  import squash_io_pkg::*;
#(
  parameter int N        = 4,
  parameter int PRESCALE = DEB_PRESCALE,
  parameter int STABLE   = DEB_STABLE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level_n,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic         sample_tick
);

  localparam int PCW = $clog2(PRESCALE);
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  logic [PCW-1:0] pc_r;
  logic           tick_s;

  assign tick_s      = (pc_r == PC_LAST);
  assign sample_tick = tick_s;

  // Free-running prescaler; wraps on the tick so spacing is exactly PRESCALE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= '0;
    end else if (tick_s) begin
      pc_r <= '0;
    end else begin
      pc_r <= pc_r + PCW'(1'b1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_channel #(
      .STABLE (STABLE)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick_s),
      .raw     (btn_raw[i]),
      .level_n (btn_level_n[i]),
      .press   (btn_press[i]),
      .rel     (btn_release[i])
    );
  end

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with PRESCALE=4, STABLE=3: a cycle-exact
// vector table after reset, then hand-written multi-cycle corner sequences.
module tb_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level_n;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       sample_tick;

  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] level_n;
    logic [3:0] press;
    logic [3:0] rel;
    logic       tick;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  input_debouncer #(
    .N        (4),
    .PRESCALE (4),
    .STABLE   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level_n (btn_level_n),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .sample_tick (sample_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after raw[ch] changed at a falling edge; watches 20 cycles.
  task automatic measure(input int ch, input bit to_pressed, input int lo, input int hi,
                         input string name);
    int lat;
    int scyc;
    int n_good;
    int n_bad;
    logic target;
    lat = 0; scyc = 0; n_good = 0; n_bad = 0;
    target = to_pressed ? 1'b0 : 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && btn_level_n[ch] == target) lat = c;
      if ((to_pressed ? btn_press[ch] : btn_release[ch]) == 1'b1) begin
        n_good++;
        scyc = c;
      end
      if ((to_pressed ? btn_release[ch] : btn_press[ch]) == 1'b1) n_bad++;
    end
    chk({name, "_latency_in_range"}, 32'(lat >= lo && lat <= hi), 32'd1);
    chk({name, "_strobe_count"}, 32'(n_good), 32'd1);
    chk({name, "_other_strobe"}, 32'(n_bad), 32'd0);
    chk({name, "_strobe_with_level"}, 32'(scyc), 32'(lat));
  endtask

  initial begin
    int last_tick;
    int n_tick;
    int bad;
    int found;
    int pcnt [4];
    int pcyc [4];

    n_vec = 0;
    n_err = 0;

    // Edge e = i+1 after reset release. Ticks visible after edges 3,7,11,...
    // ch0 pressed edges 1..14: press accepted at edge 12, release at edge 28.
    for (int i = 0; i < NV; i++) begin
      vecs[i].raw     = (i + 1 <= 14) ? 4'b0001 : 4'b0000;
      vecs[i].level_n = (i + 1 >= 12 && i + 1 < 28) ? 4'b1110 : 4'b1111;
      vecs[i].press   = (i + 1 == 12) ? 4'b0001 : 4'b0000;
      vecs[i].rel     = (i + 1 == 28) ? 4'b0001 : 4'b0000;
      vecs[i].tick    = ((i + 1) % 4 == 3) ? 1'b1 : 1'b0;
    end

    rst_n   = 1'b0;
    btn_raw = 4'b0000;
    #12;
    chk("reset_level", 32'(btn_level_n), 32'hF);
    chk("reset_press", 32'(btn_press), 32'h0);
    chk("reset_release", 32'(btn_release), 32'h0);
    chk("reset_tick", 32'(sample_tick), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      btn_raw = vecs[i].raw;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_level", i), 32'(btn_level_n), 32'(vecs[i].level_n));
      chk($sformatf("vec%0d_press", i), 32'(btn_press), 32'(vecs[i].press));
      chk($sformatf("vec%0d_release", i), 32'(btn_release), 32'(vecs[i].rel));
      chk($sformatf("vec%0d_tick", i), 32'(sample_tick), 32'(vecs[i].tick));
      @(negedge clk);
    end

    // Tick spacing over 100 cycles.
    last_tick = -1;
    n_tick = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (sample_tick) begin
        if (last_tick >= 0) chk("tick_gap", 32'(i - last_tick), 32'd4);
        last_tick = i;
        n_tick++;
      end
    end
    chk("tick_count_100", 32'(n_tick), 32'd25);

    // Bounce on ch2: toggle every 5 cycles for 60 cycles, ending low.
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      btn_raw[2] = (k % 2 == 0) ? 1'b1 : 1'b0;
      for (int j = 0; j < 5; j++) begin
        @(posedge clk);
        #1;
        if (btn_level_n[2] !== 1'b1 || btn_press[2] !== 1'b0 || btn_release[2] !== 1'b0) bad++;
      end
      @(negedge clk);
    end
    chk("bounce_rejected", 32'(bad), 32'd0);
    btn_raw[2] = 1'b1;
    measure(2, 1'b1, 11, 14, "bounce_hold");

    // Press then release on ch3.
    @(negedge clk);
    btn_raw[3] = 1'b1;
    measure(3, 1'b1, 11, 14, "press3");
    @(negedge clk);
    btn_raw[3] = 1'b0;
    measure(3, 1'b0, 11, 14, "release3");

    // Simultaneous press on all channels from fully released.
    @(negedge clk);
    btn_raw = 4'b0000;
    repeat (20) @(posedge clk);
    #1;
    chk("all_released", 32'(btn_level_n), 32'hF);
    @(negedge clk);
    btn_raw = 4'b1111;
    found = 0;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      @(posedge clk);
      #1;
      if (btn_press != 4'b0000) found = c;
    end
    chk("simul_found", 32'(found != 0), 32'd1);
    chk("simul_press", 32'(btn_press), 32'hF);
    chk("simul_level", 32'(btn_level_n), 32'h0);
    @(posedge clk);
    #1;
    chk("simul_press_one_cycle", 32'(btn_press), 32'h0);

    // Asynchronous reset mid-run with all buttons held.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_level", 32'(btn_level_n), 32'hF);
    chk("async_reset_press", 32'(btn_press), 32'h0);
    chk("async_reset_release", 32'(btn_release), 32'h0);
    chk("async_reset_tick", 32'(sample_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int ch = 0; ch < 4; ch++) begin
      pcnt[ch] = 0;
      pcyc[ch] = 0;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 4; ch++) begin
        if (btn_press[ch]) begin
          pcnt[ch]++;
          pcyc[ch] = c;
        end
      end
      if (btn_release != 4'b0000) bad++;
    end
    for (int ch = 0; ch < 4; ch++) begin
      chk($sformatf("rehold_press_count%0d", ch), 32'(pcnt[ch]), 32'd1);
      chk($sformatf("rehold_latency%0d", ch), 32'(pcyc[ch] >= 11 && pcyc[ch] <= 14), 32'd1);
    end
    chk("rehold_no_release", 32'(bad), 32'd0);
    chk("rehold_level", 32'(btn_level_n), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_input_debouncer
